// File: rtl/rs_core_arbiter_pkg.sv
// Shared types and helpers for the reed_solomon core arbiter.
package rs_core_arbiter_pkg;

    localparam int JOBCNT_W = 16;

    typedef enum logic [2:0] {
        S_CORE_RST,
        S_ARB,
        S_LOAD,
        S_START,
        S_RUN
    } arb_state_t;

    // (base + ofs) mod n, for base < n and ofs <= n
    function automatic int wrap_add(input int base, input int ofs, input int n);
        int s;
        s = base + ofs;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rs_core_arbiter_if.sv
// Requester and core-control bundle between the arbiter and its surroundings.
interface rs_core_arbiter_if #(
    parameter int NREQ = 2
);
    import rs_core_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     go;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic [IDX_W-1:0]    owner_idx;
    logic                owner_valid;
    logic                core_rst;
    logic                ap_start;
    logic                ap_ready;
    logic                ap_done;
    logic                busy;
    logic [JOBCNT_W-1:0] job_cnt;

    // requester/core side
    modport master (
        output req, go, ap_ready, ap_done,
        input  gnt, done, err, owner_idx, owner_valid, core_rst, ap_start, busy, job_cnt
    );

    // arbiter side
    modport slave (
        input  req, go, ap_ready, ap_done,
        output gnt, done, err, owner_idx, owner_valid, core_rst, ap_start, busy, job_cnt
    );
endinterface

// File: rtl/rs_core_arbiter_rr_picker.sv
// Round-robin pick: first set req bit at or after rr_ptr, wrapping modulo NREQ.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module rs_core_arbiter_rr_picker
    import rs_core_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan farthest offset first so the nearest set bit is the last one written.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'(wrap_add(int'(rr_ptr), k, NREQ));
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rs_core_arbiter.sv
// Grants one reed_solomon core round-robin, soft-resets it between jobs, runs ap_ctrl_hs with timeout.
// Latency: req->gnt 1 cycle in S_ARB, go->ap_start 1 cycle; all outputs registered.
// Backpressure: ap_start held until ap_ready; req/go ignored outside arbitration/load.
module rs_core_arbiter
    import rs_core_arbiter_pkg::*;
#(
    parameter int  NREQ           = 2,
    parameter int  SOFTRST_CYCLES = 1024,
    parameter int  TIMEOUT_CYCLES = 1048576,
    localparam int IDX_W          = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    rs_core_arbiter_if.slave  bus
);

    localparam int RST_W   = $clog2(SOFTRST_CYCLES);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W   = (RST_W > TIMER_W) ? ((RST_W > 0) ? RST_W : 1)
                                               : ((TIMER_W > 0) ? TIMER_W : 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(SOFTRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [NREQ-1:0]     err_q, err_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                owner_vld_q, owner_vld_d;
    logic                core_rst_q, core_rst_d;
    logic                ap_start_q, ap_start_d;
    logic                busy_q, busy_d;
    logic [JOBCNT_W-1:0] job_cnt_q, job_cnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic                job_end;

    rs_core_arbiter_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        core_rst_d  = core_rst_q;
        ap_start_d  = ap_start_q;
        job_cnt_d   = job_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        job_end     = 1'b0;

        case (state_q)
            S_CORE_RST: begin
                core_rst_d = 1'b1;
                if (cnt_q == RST_LAST) begin
                    core_rst_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ARB: begin
                if (pick_any) begin
                    gnt_d       = NREQ'(1) << pick_idx;
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    rr_ptr_d    = IDX_W'(wrap_add(int'(pick_idx), 1, NREQ));
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.go[owner_q]) begin
                    ap_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_START;
                end else if (!bus.req[owner_q]) begin
                    // withdrawn before start: core never touched, so no soft reset
                    gnt_d       = '0;
                    owner_vld_d = 1'b0;
                    state_d     = S_ARB;
                end
            end
            S_START, S_RUN: begin
                // ready+done together in S_START counts as a finished job
                job_end = bus.ap_done && ((state_q == S_RUN) || bus.ap_ready);
                if (job_end || (cnt_q == TO_LAST)) begin
                    if (job_end) begin
                        done_d[owner_q] = 1'b1;
                        if (job_cnt_q != '1) job_cnt_d = job_cnt_q + 1'b1;
                    end else begin
                        err_d[owner_q] = 1'b1;
                    end
                    gnt_d       = '0;
                    owner_vld_d = 1'b0;
                    ap_start_d  = 1'b0;
                    core_rst_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_CORE_RST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((state_q == S_START) && bus.ap_ready) begin
                        ap_start_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end
            default: begin
                core_rst_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_CORE_RST;
            end
        endcase

        busy_d = (state_d != S_ARB);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_CORE_RST;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            core_rst_q  <= 1'b1;
            ap_start_q  <= 1'b0;
            busy_q      <= 1'b1;
            job_cnt_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            core_rst_q  <= core_rst_d;
            ap_start_q  <= ap_start_d;
            busy_q      <= busy_d;
            job_cnt_q   <= job_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.owner_idx   = owner_q;
    assign bus.owner_valid = owner_vld_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.ap_start    = ap_start_q;
    assign bus.busy        = busy_q;
    assign bus.job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_rs_core_arbiter.sv
// Bench for rs_core_arbiter: two requesters, 1024-cycle soft reset, 64-cycle timeout.
module tb_rs_core_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    typedef struct {
        int idx;
        bit is_err;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    exp_t         mon_e;
    logic [N-1:0] mon_done_exp;
    logic [N-1:0] mon_err_exp;

    rs_core_arbiter_if #(.NREQ(N)) bus ();

    rs_core_arbiter #(
        .NREQ           (N),
        .SOFTRST_CYCLES (1024),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Completion scoreboard: each done/err pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (resetn && (bus.done !== '0 || bus.err !== '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL completion_unexpected: done=%b err=%b, expected no completion", bus.done, bus.err);
            end else begin
                mon_e        = exp_q.pop_front();
                mon_done_exp = mon_e.is_err ? '0 : (N'(1) << mon_e.idx);
                mon_err_exp  = mon_e.is_err ? (N'(1) << mon_e.idx) : '0;
                if (bus.done !== mon_done_exp || bus.err !== mon_err_exp) begin
                    errors++;
                    $display("FAIL completion_kind: done=%b err=%b, expected done=%b err=%b",
                             bus.done, bus.err, mon_done_exp, mon_err_exp);
                end
            end
            checks++;
            if (bus.gnt !== '0) begin
                errors++;
                $display("FAIL gnt_on_completion: gnt=%b, expected 00", bus.gnt);
            end
        end
    end

    task automatic measure_core_rst(input string name);
        int n = 0;
        while (bus.core_rst === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL %s core_rst_len: got %0d cycles, expected 1024", name, n);
        end
    endtask

    task automatic apply_reset();
        resetn       = 1'b0;
        bus.req      = '0;
        bus.go       = '0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        measure_core_rst("reset");
    endtask

    // Called on the negedge where gnt should already show idx.
    task automatic do_job(input int idx, input int go_dly, input int rdy_at, input int done_at,
                          input bit exp_err, input string name);
        logic [N-1:0] g;
        int   n;
        int   want_n;
        exp_t e;
        g = N'(1) << idx;
        n = 0;
        checks++;
        if (bus.gnt !== g || bus.owner_idx !== IW'(idx) || bus.owner_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: gnt=%b owner_idx=%0d owner_valid=%b, expected gnt=%b owner_idx=%0d owner_valid=1",
                     name, bus.gnt, bus.owner_idx, bus.owner_valid, g, idx);
        end
        repeat (go_dly) @(negedge clk);
        bus.go = g;
        @(negedge clk);
        bus.go = '0;
        checks++;
        if (bus.ap_start !== 1'b1) begin
            errors++;
            $display("FAIL %s go_to_start: ap_start=%b, expected 1", name, bus.ap_start);
        end
        e.idx    = idx;
        e.is_err = exp_err;
        exp_q.push_back(e);
        while (bus.done === '0 && bus.err === '0 && n < 200) begin
            checks++;
            if (bus.ap_start !== (n <= rdy_at)) begin
                errors++;
                $display("FAIL %s ap_start_hold: cycle %0d ap_start=%b, expected %b", name, n, bus.ap_start, (n <= rdy_at));
            end
            bus.ap_ready = (n == rdy_at);
            bus.ap_done  = (n == done_at);
            @(negedge clk);
            n++;
        end
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        want_n = exp_err ? 64 : done_at + 1;
        checks++;
        if (n != want_n) begin
            errors++;
            $display("FAIL %s completion_latency: got %0d cycles after ap_start, expected %0d", name, n, want_n);
        end
        checks++;
        if (bus.gnt !== '0 || bus.core_rst !== 1'b1 || bus.ap_start !== 1'b0) begin
            errors++;
            $display("FAIL %s post_job: gnt=%b core_rst=%b ap_start=%b, expected 00/1/0",
                     name, bus.gnt, bus.core_rst, bus.ap_start);
        end
        measure_core_rst(name);
    endtask

    task automatic check_job_cnt(input int want, input string name);
        checks++;
        if (bus.job_cnt !== 16'(want)) begin
            errors++;
            $display("FAIL %s job_cnt: got %0d, expected %0d", name, bus.job_cnt, want);
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        bus.req      = '0;
        bus.go       = '0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.owner_idx, bus.owner_valid, bus.core_rst, bus.ap_start, bus.busy, bus.job_cnt}
            !== {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: gnt=%b done=%b err=%b idx=%0d vld=%b core_rst=%b ap_start=%b busy=%b job_cnt=%0d, expected 00 00 00 0 0 1 0 1 0",
                     bus.gnt, bus.done, bus.err, bus.owner_idx, bus.owner_valid, bus.core_rst, bus.ap_start, bus.busy, bus.job_cnt);
        end
        resetn = 1'b1;
        measure_core_rst("reset");
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
            errors++;
            $display("FAIL arb_entry: busy=%b gnt=%b, expected 0 00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_single_job();
        bus.req = 2'b01;
        @(negedge clk);
        do_job(0, 2, 5, 45, 1'b0, "single");
        bus.req = '0;
        check_job_cnt(1, "single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            do_job(j % 2, 1, 2, 10, 1'b0, "round_robin");
        end
        bus.req = '0;
        check_job_cnt(4, "round_robin");
    endtask

    task automatic test_withdraw();
        bus.req = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL withdraw_grant: gnt=%b, expected 10", bus.gnt);
        end
        bus.go = 2'b01;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (bus.ap_start !== 1'b0 || bus.gnt !== 2'b10) begin
                errors++;
                $display("FAIL non_owner_go: ap_start=%b gnt=%b, expected 0 10", bus.ap_start, bus.gnt);
            end
        end
        bus.go  = '0;
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b00 || bus.core_rst !== 1'b0 || bus.owner_valid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_release: gnt=%b core_rst=%b owner_valid=%b, expected 00 0 0",
                     bus.gnt, bus.core_rst, bus.owner_valid);
        end
        @(negedge clk);
        do_job(0, 0, 1, 5, 1'b0, "after_withdraw");
        bus.req = '0;
        check_job_cnt(5, "withdraw");
    endtask

    task automatic test_timeout();
        bus.req = 2'b10;
        @(negedge clk);
        do_job(1, 1, 3, 1000, 1'b1, "timeout");
        bus.req = '0;
        check_job_cnt(5, "timeout");
    endtask

    task automatic test_done_boundaries();
        bus.req = 2'b01;
        @(negedge clk);
        do_job(0, 0, 4, 4, 1'b0, "ready_with_done");
        @(negedge clk);
        do_job(0, 0, 2, 63, 1'b0, "done_at_timeout");
        bus.req = '0;
        check_job_cnt(7, "boundaries");
    endtask

    task automatic test_reset_mid_run();
        bus.req = 2'b01;
        @(negedge clk);
        bus.go = 2'b01;
        @(negedge clk);
        bus.go       = '0;
        bus.ap_ready = 1'b1;
        @(negedge clk);
        bus.ap_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.ap_start !== 1'b0 || bus.gnt !== 2'b01 || bus.job_cnt !== 16'd7) begin
            errors++;
            $display("FAIL mid_run_state: busy=%b ap_start=%b gnt=%b job_cnt=%0d, expected 1 0 01 7",
                     bus.busy, bus.ap_start, bus.gnt, bus.job_cnt);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.owner_idx, bus.owner_valid, bus.core_rst, bus.ap_start, bus.busy, bus.job_cnt}
            !== {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: gnt=%b done=%b err=%b idx=%0d vld=%b core_rst=%b ap_start=%b busy=%b job_cnt=%0d, expected 00 00 00 0 0 1 0 1 0",
                     bus.gnt, bus.done, bus.err, bus.owner_idx, bus.owner_valid, bus.core_rst, bus.ap_start, bus.busy, bus.job_cnt);
        end
        bus.ap_done = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 2'b00 || bus.core_rst !== 1'b1 || bus.job_cnt !== 16'd0) begin
                errors++;
                $display("FAIL done_in_reset: done=%b core_rst=%b job_cnt=%0d, expected 00 1 0",
                         bus.done, bus.core_rst, bus.job_cnt);
            end
        end
        bus.ap_done = 1'b0;
        bus.req     = '0;
        resetn      = 1'b1;
        measure_core_rst("post_reset");
    endtask

    initial begin
        clk          = 1'b0;
        resetn       = 1'b0;
        checks       = 0;
        errors       = 0;
        bus.req      = '0;
        bus.go       = '0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;

        test_reset();
        test_single_job();
        test_round_robin();
        test_withdraw();
        test_timeout();
        test_done_boundaries();
        test_reset_mid_run();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
